// File: rtl/nerv_axil_monitor.sv
// nerv_axil_monitor -- passive AXI4-Lite source-side protocol monitor.
// Checks handshake stability, response ordering, outstanding limit and wait
// timeouts. Reports sticky flags, a first-error snapshot and a 1-cycle pulse.
// Optional feature macro: NERV_AXIL_MON_STATS_EN builds the wr_done/rd_done
// statistics counters; without it those outputs are tied to zero.
//
// Handshake semantics observed on every channel: a transfer happens in a cycle
// with VALID && READY. Once VALID is high with READY low, the source must keep
// VALID high and the payload bit-identical until the transfer happens.
module nerv_axil_monitor #(
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int MAX_OUTSTANDING = 1,
   parameter int MAX_WAIT        = 16,
   parameter int READ_ONLY       = 0,
   parameter int COUNT_WIDTH     = 16
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      awvalid,
   input  logic                      awready,
   input  logic [ADDR_WIDTH-1:0]     awaddr,
   input  logic [2:0]                awprot,
   input  logic                      wvalid,
   input  logic                      wready,
   input  logic [DATA_WIDTH-1:0]     wdata,
   input  logic [DATA_WIDTH/8-1:0]   wstrb,
   input  logic                      bvalid,
   input  logic                      bready,
   input  logic [1:0]                bresp,
   input  logic                      arvalid,
   input  logic                      arready,
   input  logic [ADDR_WIDTH-1:0]     araddr,
   input  logic [2:0]                arprot,
   input  logic                      rvalid,
   input  logic                      rready,
   input  logic [DATA_WIDTH-1:0]     rdata,
   input  logic [1:0]                rresp,
   output logic [7:0]                err,
   output logic [7:0]                err_first,
   output logic                      err_pulse,
   output logic [3:0]                wr_outstanding,
   output logic [3:0]                rd_outstanding,
   output logic [COUNT_WIDTH-1:0]    wr_done,
   output logic [COUNT_WIDTH-1:0]    rd_done
);
   localparam int         STRB_WIDTH = DATA_WIDTH / 8;
   localparam bit         WR_EN      = (READ_ONLY == 0);
   localparam logic [3:0] MAX_OUT    = 4'(MAX_OUTSTANDING);
   localparam logic [7:0] WAIT_TOP   = 8'(MAX_WAIT);
   localparam logic [7:0] WAIT_LAST  = 8'(MAX_WAIT - 1);
   // Channel index equals its stability error bit
   localparam int CH_AW = 0, CH_W = 1, CH_AR = 2, CH_B = 3, CH_R = 4;

   logic [4:0] valid_v, ready_v, chan_en, stall_v, hs_v, same_v, prev_stall;
   logic [ADDR_WIDTH+2:0]            aw_pay, aw_prev, ar_pay, ar_prev;
   logic [DATA_WIDTH+STRB_WIDTH-1:0] w_pay, w_prev;
   logic [DATA_WIDTH+1:0]            r_pay, r_prev;
   logic [1:0]                       b_prev;
   logic [3:0] aw_cnt, w_cnt, rd_cnt;
   logic [7:0] wait_cnt [5];
   logic       hist_valid;
   logic [7:0] viol;

   assign valid_v = {rvalid, bvalid, arvalid, wvalid, awvalid};
   assign ready_v = {rready, bready, arready, wready, awready};
   // Write channels are invisible in a read-only instance
   assign chan_en = WR_EN ? 5'b11111 : 5'b10100;
   assign stall_v = valid_v & ~ready_v & chan_en;
   assign hs_v    = valid_v & ready_v & chan_en;

   assign aw_pay = {awprot, awaddr};
   assign w_pay  = {wstrb, wdata};
   assign ar_pay = {arprot, araddr};
   assign r_pay  = {rresp, rdata};
   assign same_v = {r_pay == r_prev, bresp == b_prev, ar_pay == ar_prev,
                    w_pay == w_prev, aw_pay == aw_prev};

   assign wr_outstanding = (aw_cnt < w_cnt) ? aw_cnt : w_cnt;
   assign rd_outstanding = rd_cnt;

   // Saturating up/down count; a request and response together leave it unchanged
   function automatic logic [3:0] cnt_next(input logic [3:0] cnt, input logic inc,
                                           input logic dec);
      if (inc && !dec && cnt != MAX_OUT) return cnt + 4'd1;
      if (dec && !inc && cnt != 4'd0)    return cnt - 4'd1;
      return cnt;
   endfunction

   // Violations of this cycle's inputs against the registered history
   always_comb begin
      viol      = '0;
      viol[4:0] = prev_stall & ~(valid_v & same_v);
      viol[5]   = (WR_EN && bvalid && (aw_cnt == 4'd0 || w_cnt == 4'd0)) ||
                  (rvalid && rd_cnt == 4'd0);
      viol[6]   = (hs_v[CH_AR] && !hs_v[CH_R] && rd_cnt == MAX_OUT) ||
                  (hs_v[CH_AW] && !hs_v[CH_B] && aw_cnt == MAX_OUT) ||
                  (hs_v[CH_W]  && !hs_v[CH_B] && w_cnt  == MAX_OUT);
      for (int i = 0; i < 5; i++) begin
         if (stall_v[i] && wait_cnt[i] == WAIT_LAST) viol[7] = 1'b1;
      end
      // History is meaningless in the first cycle after reset
      if (!hist_valid) viol = '0;
   end

   // Outstanding counters, wait counters and one-cycle channel history
   always_ff @(posedge clock) begin
      if (reset) begin
         hist_valid <= 1'b0;
         aw_cnt     <= '0;
         w_cnt      <= '0;
         rd_cnt     <= '0;
         prev_stall <= '0;
         aw_prev    <= '0;
         w_prev     <= '0;
         b_prev     <= '0;
         ar_prev    <= '0;
         r_prev     <= '0;
         for (int i = 0; i < 5; i++) wait_cnt[i] <= '0;
      end else begin
         hist_valid <= 1'b1;
         aw_cnt     <= cnt_next(aw_cnt, hs_v[CH_AW], hs_v[CH_B]);
         w_cnt      <= cnt_next(w_cnt,  hs_v[CH_W],  hs_v[CH_B]);
         rd_cnt     <= cnt_next(rd_cnt, hs_v[CH_AR], hs_v[CH_R]);
         prev_stall <= stall_v;
         aw_prev    <= aw_pay;
         w_prev     <= w_pay;
         b_prev     <= bresp;
         ar_prev    <= ar_pay;
         r_prev     <= r_pay;
         for (int i = 0; i < 5; i++) begin
            if (!stall_v[i])               wait_cnt[i] <= '0;
            else if (wait_cnt[i] != WAIT_TOP) wait_cnt[i] <= wait_cnt[i] + 8'd1;
         end
      end
   end

   // Sticky flags, first-error snapshot and violation pulse
   always_ff @(posedge clock) begin
      if (reset) begin
         err       <= '0;
         err_first <= '0;
         err_pulse <= 1'b0;
      end else begin
         err       <= err | viol;
         err_pulse <= |viol;
         if (err == 8'd0 && viol != 8'd0) err_first <= viol;
      end
   end

`ifdef NERV_AXIL_MON_STATS_EN
   // Completed response handshakes, wrapping
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_done <= '0;
         rd_done <= '0;
      end else begin
         wr_done <= wr_done + COUNT_WIDTH'(hs_v[CH_B]);
         rd_done <= rd_done + COUNT_WIDTH'(hs_v[CH_R]);
      end
   end
`else
   assign wr_done = '0;
   assign rd_done = '0;
`endif

endmodule

// File: tb/tb_nerv_axil_monitor.sv
// Bench for nerv_axil_monitor: a full-featured instance (u0) and a read-only
// instance with different limits (u1) share one stimulus stream. A rule-level
// model predicts every output each cycle; directed scenarios add fixed values.
module tb_nerv_axil_monitor;

`ifdef NERV_AXIL_MON_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif
   localparam int NM = 2;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic reset;

   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [31:0] awaddr, wdata, araddr, rdata;
   logic [2:0]  awprot, arprot;
   logic [3:0]  wstrb;
   logic [1:0]  bresp, rresp;

   logic [7:0]  err0, first0, err1, first1;
   logic        pulse0, pulse1;
   logic [3:0]  wro0, rro0, wro1, rro1;
   logic [15:0] wrd0, rdd0, wrd1, rdd1;

   nerv_axil_monitor #(.MAX_OUTSTANDING(1), .MAX_WAIT(16), .READ_ONLY(0)) u0 (
      .clock(clk), .reset(reset),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
      .bvalid(bvalid), .bready(bready), .bresp(bresp),
      .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
      .err(err0), .err_first(first0), .err_pulse(pulse0),
      .wr_outstanding(wro0), .rd_outstanding(rro0), .wr_done(wrd0), .rd_done(rdd0));

   nerv_axil_monitor #(.MAX_OUTSTANDING(3), .MAX_WAIT(4), .READ_ONLY(1)) u1 (
      .clock(clk), .reset(reset),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
      .bvalid(bvalid), .bready(bready), .bresp(bresp),
      .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
      .err(err1), .err_first(first1), .err_pulse(pulse1),
      .wr_outstanding(wro1), .rd_outstanding(rro1), .wr_done(wrd1), .rd_done(rdd1));

   // ---------------- scoreboard / reference model ----------------
   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
      end
   endtask

   int          m_maxo [NM] = '{1, 3};
   int          m_maxw [NM] = '{16, 4};
   bit          m_ro   [NM] = '{1'b0, 1'b1};
   int          m_rd [NM], m_aw [NM], m_w [NM], m_wrd [NM], m_rdd [NM];
   int          m_wait [NM][5];
   bit          m_pstall [NM][5];
   logic [63:0] m_ppay [NM][5];
   bit          m_hist [NM], m_pulse [NM];
   logic [7:0]  m_err [NM], m_first [NM];

   function automatic int clamp(input int x, input int hi);
      if (x < 0) return 0;
      if (x > hi) return hi;
      return x;
   endfunction

   // Apply the monitor's rules to the inputs of the cycle that just ended
   task automatic model_step();
      bit          v [5], r [5], hs [5], is_wr;
      logic [63:0] p [5];
      logic [7:0]  viol;
      v[0] = awvalid; r[0] = awready; p[0] = 64'({awprot, awaddr});
      v[1] = wvalid;  r[1] = wready;  p[1] = 64'({wstrb, wdata});
      v[2] = arvalid; r[2] = arready; p[2] = 64'({arprot, araddr});
      v[3] = bvalid;  r[3] = bready;  p[3] = 64'(bresp);
      v[4] = rvalid;  r[4] = rready;  p[4] = 64'({rresp, rdata});
      for (int m = 0; m < NM; m++) begin
         if (reset) begin
            m_rd[m] = 0; m_aw[m] = 0; m_w[m] = 0; m_wrd[m] = 0; m_rdd[m] = 0;
            m_hist[m] = 0; m_pulse[m] = 0; m_err[m] = 0; m_first[m] = 0;
            for (int c = 0; c < 5; c++) begin
               m_wait[m][c] = 0; m_pstall[m][c] = 0; m_ppay[m][c] = 0;
            end
         end else begin
            viol = 0;
            for (int c = 0; c < 5; c++) begin
               is_wr = (c == 0 || c == 1 || c == 3);
               hs[c] = v[c] && r[c] && !(is_wr && m_ro[m]);
               if (!(is_wr && m_ro[m])) begin
                  if (m_pstall[m][c] && (!v[c] || p[c] != m_ppay[m][c])) viol[c] = 1'b1;
                  if (v[c] && !r[c] && m_wait[m][c] + 1 == m_maxw[m]) viol[7] = 1'b1;
               end
            end
            if (!m_ro[m] && v[3] && (m_aw[m] == 0 || m_w[m] == 0)) viol[5] = 1'b1;
            if (v[4] && m_rd[m] == 0) viol[5] = 1'b1;
            if (hs[2] && !hs[4] && m_rd[m] == m_maxo[m]) viol[6] = 1'b1;
            if (hs[0] && !hs[3] && m_aw[m] == m_maxo[m]) viol[6] = 1'b1;
            if (hs[1] && !hs[3] && m_w[m]  == m_maxo[m]) viol[6] = 1'b1;
            if (!m_hist[m]) viol = 0;
            if (viol != 0 && m_err[m] == 0) m_first[m] = viol;
            m_err[m]   = m_err[m] | viol;
            m_pulse[m] = (viol != 0);
            m_rd[m] = clamp(m_rd[m] + int'(hs[2]) - int'(hs[4]), m_maxo[m]);
            m_aw[m] = clamp(m_aw[m] + int'(hs[0]) - int'(hs[3]), m_maxo[m]);
            m_w[m]  = clamp(m_w[m]  + int'(hs[1]) - int'(hs[3]), m_maxo[m]);
            m_wrd[m] = (m_wrd[m] + int'(hs[3])) % 65536;
            m_rdd[m] = (m_rdd[m] + int'(hs[4])) % 65536;
            for (int c = 0; c < 5; c++) begin
               m_wait[m][c]   = (v[c] && !r[c]) ? clamp(m_wait[m][c] + 1, m_maxw[m]) : 0;
               m_pstall[m][c] = v[c] && !r[c];
               m_ppay[m][c]   = p[c];
            end
            m_hist[m] = 1;
         end
      end
   endtask

   task automatic check_all();
      check_eq("u0.err",       err0,   m_err[0]);
      check_eq("u0.err_first", first0, m_first[0]);
      check_eq("u0.err_pulse", pulse0, m_pulse[0]);
      check_eq("u0.wr_out",    wro0,   (m_aw[0] < m_w[0]) ? m_aw[0] : m_w[0]);
      check_eq("u0.rd_out",    rro0,   m_rd[0]);
      check_eq("u0.wr_done",   wrd0,   STATS ? m_wrd[0] : 0);
      check_eq("u0.rd_done",   rdd0,   STATS ? m_rdd[0] : 0);
      check_eq("u1.err",       err1,   m_err[1]);
      check_eq("u1.err_first", first1, m_first[1]);
      check_eq("u1.err_pulse", pulse1, m_pulse[1]);
      check_eq("u1.wr_out",    wro1,   (m_aw[1] < m_w[1]) ? m_aw[1] : m_w[1]);
      check_eq("u1.rd_out",    rro1,   m_rd[1]);
      check_eq("u1.wr_done",   wrd1,   STATS ? m_wrd[1] : 0);
      check_eq("u1.rd_done",   rdd1,   STATS ? m_rdd[1] : 0);
   endtask

   // ---------------- driver tasks ----------------
   // One clock: model consumes this cycle's inputs, outputs checked half a cycle later
   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      cyc++;
      check_all();
   endtask

   task automatic idle();
      awvalid = 0; awready = 0; wvalid = 0; wready = 0; bvalid = 0; bready = 0;
      arvalid = 0; arready = 0; rvalid = 0; rready = 0;
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b1;
      cycle();
      reset = 1'b0;
   endtask

   function automatic bit pct(input int p);
      return $urandom_range(0, 99) < p;
   endfunction

   // Mostly protocol-abiding random traffic with occasional injected faults
   task automatic rand_drive();
      int wo;
      wo = (m_aw[0] < m_w[0]) ? m_aw[0] : m_w[0];
      if (!(awvalid && !awready) || pct(2)) begin
         awvalid = pct(m_aw[0] < m_maxo[0] ? 35 : 5); awaddr = $urandom; awprot = 3'($urandom);
      end
      if (!(wvalid && !wready) || pct(2)) begin
         wvalid = pct(m_w[0] < m_maxo[0] ? 35 : 5); wdata = $urandom; wstrb = 4'($urandom);
      end
      if (!(arvalid && !arready) || pct(2)) begin
         arvalid = pct(m_rd[0] < m_maxo[0] ? 35 : 5); araddr = $urandom; arprot = 3'($urandom);
      end
      if (!(bvalid && !bready) || pct(2)) begin
         bvalid = pct(wo > 0 ? 50 : 3); bresp = 2'($urandom);
      end
      if (!(rvalid && !rready) || pct(2)) begin
         rvalid = pct(m_rd[0] > 0 ? 50 : 3); rdata = $urandom; rresp = 2'($urandom);
      end
      awready = pct(60); wready = pct(60); arready = pct(60);
      bready = pct(60); rready = pct(60);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      idle();
      awaddr = 0; awprot = 0; wdata = 0; wstrb = 0; bresp = 0;
      araddr = 0; arprot = 0; rdata = 0; rresp = 0;
      reset = 1'b1;
      cycle();
      do_reset();
      check_eq("reset.err", err0, 8'h00);
      check_eq("reset.rd_out", rro0, 4'd0);

      // Legal read: AR in cycle 2, R in cycle 5
      cycle();
      arvalid = 1; arready = 1; araddr = 32'h40; cycle(); idle();
      check_eq("rd.out_c3", rro0, 4'd1);
      cycle(); cycle();
      check_eq("rd.out_c5", rro0, 4'd1);
      rvalid = 1; rready = 1; rdata = 32'hCAFE; rresp = 0; cycle(); idle();
      check_eq("rd.out_c6", rro0, 4'd0);
      check_eq("rd.err", err0, 8'h00);
      check_eq("rd.done", rdd0, STATS ? 16'd1 : 16'd0);

      // Unstable AR address while stalled
      do_reset();
      cycle(); cycle();
      arvalid = 1; arready = 0; araddr = 32'h100; arprot = 0; cycle();
      araddr = 32'h104; cycle();
      check_eq("unst.err", err0, 8'h04);
      check_eq("unst.pulse", pulse0, 1'b1);
      check_eq("unst.first", first0, 8'h04);
      arready = 1; cycle(); idle(); cycle();
      check_eq("unst.pulse_off", pulse0, 1'b0);

      // Write with W before AW, B afterwards
      do_reset();
      cycle();
      wvalid = 1; wready = 1; wdata = 32'h55; wstrb = 4'hF; cycle(); idle(); cycle();
      awvalid = 1; awready = 1; awaddr = 32'h80; cycle(); idle();
      check_eq("wr.out", wro0, 4'd1);
      cycle();
      bvalid = 1; bready = 1; bresp = 0; cycle(); idle();
      check_eq("wr.err", err0, 8'h00);
      check_eq("wr.out_end", wro0, 4'd0);
      check_eq("wr.done", wrd0, STATS ? 16'd1 : 16'd0);

      // Early B (no AW yet)
      do_reset();
      cycle();
      wvalid = 1; wready = 1; cycle(); idle();
      bvalid = 1; bready = 1; cycle(); idle();
      check_eq("earlyb.err", err0, 8'h20);

      // Two reads accepted with limit 1
      do_reset();
      cycle();
      arvalid = 1; arready = 1; cycle(); cycle(); idle();
      check_eq("ovf.err", err0, 8'h40);
      check_eq("ovf.out", rro0, 4'd1);
      cycle();
      check_eq("ovf.out_hold", rro0, 4'd1);

      // AW stalled for 16 cycles
      do_reset();
      awvalid = 1; awready = 0; awaddr = 32'h200; awprot = 3'd1;
      repeat (15) cycle();
      check_eq("tmo.err_early", err0, 8'h00);
      cycle();
      check_eq("tmo.err", err0, 8'h80);
      check_eq("tmo.pulse", pulse0, 1'b1);
      awready = 1; cycle(); idle();
      repeat (3) cycle();
      check_eq("tmo.sticky", err0, 8'h80);
      do_reset();
      check_eq("tmo.cleared", err0, 8'h00);

      // Reset discards an outstanding read; the late R is unexpected
      cycle();
      arvalid = 1; arready = 1; cycle(); idle();
      do_reset();
      cycle();
      rvalid = 1; rready = 1; cycle(); idle();
      check_eq("rstmid.err", err0, 8'h20);

      // Read-only instance: random write traffic plus a legal read
      do_reset();
      for (int k = 1; k <= 12; k++) begin
         awvalid = pct(50); awready = pct(50); awaddr = $urandom;
         wvalid = pct(50); wready = pct(50); wdata = $urandom;
         bvalid = pct(50); bready = pct(50); bresp = 2'($urandom);
         arvalid = (k == 3); arready = (k == 3); rvalid = (k == 6); rready = (k == 6);
         rresp = 0;
         cycle();
      end
      idle(); cycle();
      check_eq("ro.err", err1, 8'h00);
      check_eq("ro.wr_out", wro1, 4'd0);
      check_eq("ro.wr_done", wrd1, 16'd0);
      check_eq("ro.rd_done", rdd1, STATS ? 16'd1 : 16'd0);

      // Random traffic in bursts separated by resets
      for (int b = 0; b < 40; b++) begin
         do_reset();
         repeat ($urandom_range(20, 80)) begin
            rand_drive();
            cycle();
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/nerv_axil_monitor.md
# nerv_axil_monitor

Synthesizable, parametrised AXI4-Lite source-side protocol monitor for the NERV AXI-Lite core's imem and dmem ports. It is a passive observer: it drives no bus signal and one instance sits beside each port. It checks handshake stability, response ordering, the outstanding-transaction limit and wait timeouts. It reports sticky error flags and a first-error snapshot, and can keep transaction statistics. Results are usable in simulation, formal, and on FPGA (flags routed to LEDs/debug registers).

## Interface
Parameters:
- ADDR_WIDTH, 32, AW/AR address width
- DATA_WIDTH, 32, W/R data width; WSTRB width is DATA_WIDTH/8
- MAX_OUTSTANDING, 1, max accepted-but-unanswered transactions per direction (1..15)
- MAX_WAIT, 16, cycles a VALID may wait for READY before timeout (2..255)
- READ_ONLY, 0, 1 = write channels ignored, write error bits forced 0 (imem use)
- COUNT_WIDTH, 16, width of statistics counters

Ports:
- clock  in  1  sole clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- awvalid/awready/awaddr[ADDR_WIDTH]/awprot[3]  in  AW channel
- wvalid/wready/wdata[DATA_WIDTH]/wstrb[DATA_WIDTH/8]  in  W channel
- bvalid/bready/bresp[2]  in  B channel
- arvalid/arready/araddr[ADDR_WIDTH]/arprot[3]  in  AR channel
- rvalid/rready/rdata[DATA_WIDTH]/rresp[2]  in  R channel
- err  out  8  sticky error flags (bit map below)
- err_first  out  8  snapshot of error bits from the first violating cycle
- err_pulse  out  1  high one cycle after any violating cycle
- wr_outstanding, rd_outstanding  out  4  current outstanding counts
- wr_done, rd_done  out  COUNT_WIDTH  completed B / R handshakes (statistics)

## Operation
- Error bits: 0 AW stable, 1 W stable, 2 AR stable, 3 B stable, 4 R stable, 5 unexpected response, 6 outstanding overflow, 7 timeout.
- Stability (bits 0-4): if a channel had VALID=1 and READY=0 in cycle n-1, then in cycle n VALID must be 1 and the payload must be bit-identical. The payload is addr+prot, data+strb, resp, or data+resp. A previous-cycle payload register per channel holds the comparison value.
- Write tracking: aw_cnt and w_cnt count independently on AW and W handshakes, so AW/W in either order is legal. A B handshake decrements both. wr_outstanding = min(aw_cnt, w_cnt).
- Unexpected response (bit 5): bvalid while aw_cnt==0 or w_cnt==0, or rvalid while rd_cnt==0. Counts are the values at the start of the cycle, so no same-cycle request→response pass-through.
- Overflow (bit 6): an AR handshake with rd_cnt==MAX_OUTSTANDING and no R handshake in the same cycle. The same rule applies to aw_cnt/w_cnt with B. The counter saturates and does not wrap.
- Timeout (bit 7): each channel has a wait counter that increments while VALID && !READY and clears otherwise. The bit is set when any counter reaches MAX_WAIT. The counter saturates at MAX_WAIT.
- Simultaneous request and response handshake in one cycle: the count is unchanged.
- Only rising edges matter: err ORs in new violations and never clears except by reset. err_first loads on the first cycle with any violation and is frozen after.
- READ_ONLY=1: write counters stay 0, bits 0, 1, 3 and write parts of 5/6/7 are masked, and wr_done stays 0.

## Timing
- Checks are combinational on cycle-n inputs against registered history. Results register at the end of cycle n and are visible in cycle n+1 (latency 1).
- Reset cycle: every output is 0. All counters, wait counters and stability history clear. Checks are suppressed while reset=1 and in the first cycle after reset (history invalid).
- Reset mid-transaction: outstanding state is discarded. A response arriving after reset with no new request flags bit 5.
- wr_done/rd_done increment by 1 per handshake and wrap modulo 2^COUNT_WIDTH.

## Configuration
- NERV_AXIL_MON_STATS_EN defined: wr_done/rd_done counters are built and operate as above.
- Not defined: no counter flops. wr_done/rd_done are tied to 0, and all checking behaviour is unchanged.

## Test plan
- Legal read: AR handshake in cycle 2, R handshake in cycle 5 with rresp=0 → err=0, rd_outstanding 1 in cycles 3-5 and 0 in cycle 6, rd_done=1.
- Unstable AR: arvalid=1, arready=0, araddr=0x100 in cycle 3, then araddr=0x104 in cycle 4 → err=0x04 and err_pulse=1 in cycle 5, err_first=0x04.
- Write out of order: W handshake in cycle 2, AW in cycle 4, B in cycle 6 → no error, wr_done=1. Running B in cycle 3 instead → err bit 5 in cycle 4.
- Overflow with MAX_OUTSTANDING=1: two AR handshakes (cycles 2, 3) and no R → err=0x40 in cycle 4, rd_outstanding stays 1.
- Timeout with MAX_WAIT=16: awvalid held 1, awready 0 for 16 cycles from cycle 1 → err bit 7 set in cycle 17. Sticky through a later reset=0 period, cleared by a 1-cycle reset.
- READ_ONLY=1 with random write-channel toggling plus a legal read → err=0, wr_outstanding=0.
